// File: rtl/cdc_bus_tx_arbiter.sv
// Source-domain side of a multi-bit CDC bus: round-robin arbitration of N requesters onto one
// held data word, handed to the destination with a toggle req/ack handshake.
module cdc_bus_tx_arbiter #(
  parameter int pNUM_REQ    = 4,
  parameter int pDATA_WIDTH = 5,
  parameter int pSTAGES     = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [pNUM_REQ-1:0]             req,
  input  logic [pNUM_REQ*pDATA_WIDTH-1:0] data_in,
  output logic [pNUM_REQ-1:0]             done,
  output logic                            busy,
  output logic [$clog2(pNUM_REQ)-1:0]     bus_owner,
  output logic [pDATA_WIDTH-1:0]          bus_data,
  output logic                            bus_req_tgl,
  input  logic                            bus_ack_tgl,
  output logic                            proto_err
);

  localparam int OW = $clog2(pNUM_REQ);

  // Handshake: a transfer is outstanding while bus_req_tgl != ack_s. bus_data is held
  // from the grant edge until the destination returns the matching ack toggle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [pSTAGES-1:0] ack_sync;
  logic              ack_s;
  logic              ack_s_q;
  logic              acked;
  logic              any_req;
  logic [OW-1:0]     rr_ptr;
  logic [OW-1:0]     winner;
  logic [OW-1:0]     owner_next;
  logic [OW:0]       scan_idx;

  assign ack_s   = ack_sync[pSTAGES-1];
  assign acked   = (ack_s == bus_req_tgl);
  assign any_req = |req;
  assign owner_next = (bus_owner == OW'(pNUM_REQ - 1)) ? '0 : bus_owner + OW'(1);

  // Scan from the farthest slot back to rr_ptr so the nearest set bit wins last.
  always_comb begin
    winner   = '0;
    scan_idx = '0;
    for (int k = pNUM_REQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, rr_ptr} + (OW+1)'(k);
      if (scan_idx >= (OW+1)'(pNUM_REQ)) begin
        scan_idx = scan_idx - (OW+1)'(pNUM_REQ);
      end
      if (req[scan_idx[OW-1:0]]) begin
        winner = scan_idx[OW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = HOLD;
      HOLD:    state_nxt = WAIT;
      WAIT:    if (acked) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_sync    <= '0;
      ack_s_q     <= 1'b0;
      done        <= '0;
      busy        <= 1'b0;
      bus_owner   <= '0;
      bus_data    <= '0;
      bus_req_tgl <= 1'b0;
      proto_err   <= 1'b0;
      rr_ptr      <= '0;
    end else begin
      ack_sync <= {ack_sync[pSTAGES-2:0], bus_ack_tgl};
      ack_s_q  <= ack_s;
      done     <= '0;
      // An ack edge before our toggle has gone out cannot belong to any transfer.
      if ((state == IDLE || state == HOLD) && (ack_s != ack_s_q)) begin
        proto_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (any_req) begin
            bus_data  <= data_in[int'(winner)*pDATA_WIDTH +: pDATA_WIDTH];
            bus_owner <= winner;
            busy      <= 1'b1;
          end
        end
        HOLD: bus_req_tgl <= ~bus_req_tgl;
        WAIT: begin
          if (acked) begin
            done[bus_owner] <= 1'b1;
            rr_ptr          <= owner_next;
          end
        end
        DONE:    busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_bus_tx_arbiter.sv
// Bench for cdc_bus_tx_arbiter: transaction-level requester/destination model with a
// round-robin reference, randomized requests, data churn and ack delays.
module tb_cdc_bus_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 5;
  localparam int S  = 2;
  localparam int OW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*W-1:0]  data_in;
  logic [N-1:0]    done;
  logic            busy;
  logic [OW-1:0]   bus_owner;
  logic [W-1:0]    bus_data;
  logic            bus_req_tgl;
  logic            bus_ack_tgl;
  logic            proto_err;

  cdc_bus_tx_arbiter #(.pNUM_REQ(N), .pDATA_WIDTH(W), .pSTAGES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .data_in     (data_in),
    .done        (done),
    .busy        (busy),
    .bus_owner   (bus_owner),
    .bus_data    (bus_data),
    .bus_req_tgl (bus_req_tgl),
    .bus_ack_tgl (bus_ack_tgl),
    .proto_err   (proto_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
  endtask

  // model state
  int             rr;
  logic           exp_tgl;
  logic [W-1:0]   exp_q[$];
  int             exp_owner;
  logic [W-1:0]   exp_word;
  bit             in_xfer;
  bit             ack_pending;
  bit             post_done;
  int             grant_cyc;
  int             ack_due;
  int             ack_cyc;
  int             cyc;
  int             n_done;
  logic [N-1:0]   prev_req;
  logic [N*W-1:0] prev_data;
  int             keep_pct;
  int             raise_pct;
  int             chg_pct;

  function automatic int pick_winner(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    rr          = 0;
    exp_tgl     = 1'b0;
    in_xfer     = 1'b0;
    ack_pending = 1'b0;
    post_done   = 1'b0;
    exp_q.delete();
    prev_req    = req;
    prev_data   = data_in;
  endtask

  task automatic apply_reset();
    rst         = 1'b1;
    bus_ack_tgl = 1'b0;
    @(negedge clk);
    cyc++;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_owner", bus_owner, 0);
    check_eq("rst_data", bus_data, 0);
    check_eq("rst_tgl", bus_req_tgl, 0);
    check_eq("rst_proto", proto_err, 0);
    rst = 1'b0;
    model_reset();
  endtask

  // one cycle: observe at negedge, then drive the next inputs
  task automatic step();
    int done_owner;
    done_owner = -1;
    @(negedge clk);
    cyc++;
    if (post_done) begin
      check_eq("busy_after_done", busy, 0);
      post_done = 1'b0;
    end
    if (!in_xfer && busy) begin
      exp_owner = pick_winner(prev_req, rr);
      check_eq("grant_has_req", exp_owner >= 0, 1);
      if (exp_owner < 0) exp_owner = 0;
      exp_word = prev_data[exp_owner*W +: W];
      check_eq("grant_owner", bus_owner, exp_owner);
      check_eq("grant_data", bus_data, exp_word);
      check_eq("tgl_in_hold", bus_req_tgl, exp_tgl);
      exp_q.push_back(exp_word);
      in_xfer   = 1'b1;
      grant_cyc = cyc;
    end else if (in_xfer && cyc == grant_cyc + 1) begin
      exp_tgl = ~exp_tgl;
      check_eq("tgl_out", bus_req_tgl, exp_tgl);
      if (exp_q.size() > 0) check_eq("dst_data", bus_data, exp_q.pop_front());
      ack_due     = cyc + $urandom_range(0, 5);
      ack_pending = 1'b1;
    end
    if (in_xfer && done != '0) begin
      check_eq("done_vec", done, 1 << exp_owner);
      check_eq("done_owner", bus_owner, exp_owner);
      check_eq("done_data", bus_data, exp_word);
      check_eq("done_ack_seen", ack_pending, 0);
      if (!ack_pending) check_eq("done_lat", cyc - ack_cyc, S + 1);
      rr          = (exp_owner + 1) % N;
      in_xfer     = 1'b0;
      ack_pending = 1'b0;
      post_done   = 1'b1;
      done_owner  = exp_owner;
      n_done++;
    end else begin
      check_eq("no_done", done, 0);
    end
    if (in_xfer && cyc - grant_cyc > 40) begin
      check_eq("xfer_timeout", cyc - grant_cyc, 0);
      in_xfer     = 1'b0;
      ack_pending = 1'b0;
      exp_q.delete();
    end
    // destination returns ack
    if (ack_pending && cyc >= ack_due) begin
      bus_ack_tgl = exp_tgl;
      ack_cyc     = cyc;
      ack_pending = 1'b0;
    end
    // requesters
    if (done_owner >= 0) begin
      if ($urandom_range(0, 99) < keep_pct) data_in[done_owner*W +: W] = W'($urandom);
      else req[done_owner] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (!req[i] && $urandom_range(0, 99) < raise_pct) begin
        req[i] = 1'b1;
        data_in[i*W +: W] = W'($urandom);
      end
    end
    if ($urandom_range(0, 99) < chg_pct) data_in = (N*W)'($urandom);
    prev_req  = req;
    prev_data = data_in;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst         = 1'b1;
    req         = '0;
    data_in     = '0;
    bus_ack_tgl = 1'b0;
    cyc         = 0;
    n_done      = 0;
    keep_pct    = 0;
    raise_pct   = 0;
    chg_pct     = 0;
    repeat (2) @(negedge clk);
    apply_reset();

    // single requester 2 with a fixed word
    req = 4'b0100;
    data_in[2*W +: W] = 5'h15;
    prev_req  = req;
    prev_data = data_in;
    run(20);
    check_eq("t1_done_count", n_done, 1);
    check_eq("t1_bus_data", bus_data, 5'h15);

    // all four, dropped on done; twice
    for (int r = 0; r < 2; r++) begin
      req = 4'b1111;
      for (int i = 0; i < N; i++) data_in[i*W +: W] = W'($urandom);
      prev_req  = req;
      prev_data = data_in;
      run(80);
    end
    check_eq("t2_done_count", n_done, 9);

    // owner 0 served, then 3 must precede 0
    req = 4'b0001;
    prev_req = req;
    run(20);
    req = 4'b1001;
    prev_req = req;
    run(40);

    // requester 1 keeps requesting after done
    keep_pct = 100;
    req = 4'b0010;
    prev_req = req;
    run(30);
    keep_pct = 0;
    run(20);

    // reset during WAIT
    req = 4'b0100;
    prev_req = req;
    for (int i = 0; i < 20 && !(in_xfer && cyc == grant_cyc + 1); i++) step();
    check_eq("t5_in_wait", in_xfer, 1);
    apply_reset();
    run(25);

    // random traffic with data churn
    keep_pct  = 30;
    raise_pct = 20;
    chg_pct   = 30;
    run(800);

    // drain, then a stray ack toggle while idle
    keep_pct  = 0;
    raise_pct = 0;
    chg_pct   = 0;
    run(120);
    check_eq("drain_busy", busy, 0);
    check_eq("proto_clean", proto_err, 0);
    bus_ack_tgl = ~bus_ack_tgl;
    for (int k = 1; k <= S + 4; k++) begin
      step();
      check_eq("proto_err", proto_err, (k >= S + 1) ? 1 : 0);
    end
    apply_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
